// File: rtl/macc_pkg.sv
// Shared definitions for the 64-bit MAC operand path.
//   DATA_W   : operand width of the MAC a/b inputs
//   RESULT_W : MAC accumulator width (operands are zero-extended)
//   MAC_LAT  : cycles from a pair on a/b to the updated MAC result
//   DEPTH    : default operand FIFO depth
//   CNT_W    : default completed-frame counter width
package macc_pkg;

   localparam int DATA_W   = 32;
   localparam int RESULT_W = 64;
   localparam int MAC_LAT  = 2;
   localparam int DEPTH    = 4;
   localparam int CNT_W    = 16;

   // IDLE: next issued pair opens a frame. ACTIVE: a frame is open.
   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } feed_state_e;

   // One buffered operand pair at the package default width.
   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              last;
   } fifo_entry_t;

endpackage

// File: rtl/macc_operand_fifo.sv
// Synchronous FIFO for operand pairs.
//   clk, rst        : clock, synchronous active-high reset (flushes)
//   wr_en, wr_data  : write request; ignored while full
//   rd_en           : pop request; ignored while empty
//   rd_data         : head entry (valid while !empty), read without latency
//   full, empty     : occupancy flags derived from the occupancy counter
module macc_operand_fifo
   import macc_pkg::*;
#(
   parameter int WIDTH = 65,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   // One extra bit so that "full" (== DEPTH) is representable.
   logic [AW:0]      occ;

   logic do_wr;
   logic do_rd;

   assign full    = (occ == (AW+1)'(DEPTH));
   assign empty   = (occ == '0);
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];

   // Storage needs no reset; occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/macc_operand_feeder.sv
// Operand feeder in front of the 64-bit AND/XOR MAC.
//   clk, rst             : clock, synchronous active-high reset (shared with the MAC)
//   in_valid/in_ready    : operand pair stream handshake; in_ready = !fifo_full
//   in_a, in_b, in_last  : operand pair and frame-end marker
//   issue_en             : 0 forces bubbles and holds the FIFO
//   a, b                 : registered operands to the MAC (0 on a bubble)
//   accumulate_enable    : 1 with the first pair of a frame (MAC restarts)
//   frame_done           : one-cycle pulse when the MAC result holds a completed frame
//   frame_count          : completed frames, wraps
//   busy                 : frame open, FIFO non-empty, or a completion in flight
module macc_operand_feeder #(
   parameter int DATA_W  = macc_pkg::DATA_W,
   parameter int DEPTH   = macc_pkg::DEPTH,
   parameter int CNT_W   = macc_pkg::CNT_W,
   parameter int MAC_LAT = macc_pkg::MAC_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_last,
   input  logic              issue_en,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic              accumulate_enable,
   output logic              frame_done,
   output logic [CNT_W-1:0]  frame_count,
   output logic              busy
);

   import macc_pkg::*;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic              last;
   } entry_t;

   localparam int ENTRY_W = 2*DATA_W + 1;

   entry_t      wr_entry;
   entry_t      head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        pop;

   feed_state_e state_q;
   feed_state_e state_d;

   // vld_pipe[0] is set while the last pair of a frame sits on a/b; each
   // further stage tracks one MAC cycle, so vld_pipe[MAC_LAT] lines up with
   // the cycle the MAC result holds the finished frame. Several frames may be
   // in flight at once, each a separate bit.
   logic [MAC_LAT:0] vld_pipe;

   assign wr_entry = '{a: in_a, b: in_b, last: in_last};

   macc_operand_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_valid),
      .wr_data (wr_entry),
      .rd_en   (issue_en),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // The MAC never stalls: every cycle is either one pair or one bubble.
   assign pop      = issue_en & ~fifo_empty;
   assign in_ready = ~fifo_full;

   // Frame tracking only moves on an issued pair; bubbles leave it alone.
   always_comb begin
      state_d = state_q;
      if (pop) begin
         case (state_q)
            IDLE:    if (!head.last) state_d = ACTIVE;
            ACTIVE:  if (head.last)  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Registered MAC drive. A bubble is a=b=0 with accumulate_enable=0: the
   // AND product is zero and the XOR leaves the MAC result untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         a                 <= '0;
         b                 <= '0;
         accumulate_enable <= 1'b0;
      end else if (pop) begin
         a                 <= head.a;
         b                 <= head.b;
         accumulate_enable <= (state_q == IDLE);
      end else begin
         a                 <= '0;
         b                 <= '0;
         accumulate_enable <= 1'b0;
      end
   end

   // Completion tracking. The counter advances on the same edge that raises
   // frame_done, so both reflect the finished frame together.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe    <= '0;
         frame_count <= '0;
      end else begin
         vld_pipe <= {vld_pipe[MAC_LAT-1:0], pop & head.last};
         if (vld_pipe[MAC_LAT-1]) begin
            frame_count <= frame_count + 1'b1;
         end
      end
   end

   assign frame_done = vld_pipe[MAC_LAT];
   assign busy       = (state_q == ACTIVE) | ~fifo_empty | (|vld_pipe);

endmodule

// File: doc/macc_operand_feeder.md
Name: macc_operand_feeder

Overview:
- Upstream stage of the 64-bit MAC. The MAC forms a bitwise-AND product of `a`/`b` and XOR-accumulates it into `result`.
- Accepts operand pairs over a valid/ready stream with a frame-end marker and buffers them in a small FIFO.
- Drives the MAC's `a`, `b` and `accumulate_enable` every cycle. `accumulate_enable`=1 restarts accumulation with the current pair.
- Pulses `frame_done` in the cycle the MAC `result` first holds a completed frame.

Parameters:
- DATA_W, 32, operand width; matches MAC `a`/`b`.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- CNT_W, 16, width of `frame_count`.
- MAC_LAT, 2, cycles from a pair on `a`/`b` to the updated MAC `result`.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input pair valid
- in_ready  out  1  feeder can accept; equals !fifo_full
- in_a  in  DATA_W  operand A
- in_b  in  DATA_W  operand B
- in_last  in  1  pair is the last of its frame
- issue_en  in  1  when 0, emit bubbles only (FIFO holds)
- a  out  DATA_W  to MAC `a`
- b  out  DATA_W  to MAC `b`
- accumulate_enable  out  1  to MAC; 1 = first pair of a frame (restart)
- frame_done  out  1  one-cycle pulse; MAC `result` holds the final frame value
- frame_count  out  CNT_W  completed frames, wraps modulo 2^CNT_W
- busy  out  1  frame open, FIFO non-empty, or `frame_done` pending

Behaviour:
- Reset (sync, rst=1 at posedge): FIFO flushed, state IDLE, delay line cleared.
  - `a`=0, `b`=0, `accumulate_enable`=0, `frame_done`=0, `frame_count`=0, `busy`=0, `in_ready`=1 in the following cycle.
  - rst=1 mid-frame discards the open frame without counting it; the MAC shares rst.
- Push: `in_valid` & `in_ready` at posedge writes {in_a, in_b, in_last}.
- Pop: FIFO non-empty & `issue_en` at posedge. The MAC never stalls, so exactly one pair or one bubble is issued per cycle.
- All outputs are registered. A popped pair appears on `a`/`b` in the cycle after the pop edge.
  - Minimum input-to-`a` latency is 2 cycles: accepted at edge N, popped at N+1, on outputs after N+1. There is no bypass.
- Bubble (no pop): `a`=0, `b`=0, `accumulate_enable`=0. AND gives 0 and XOR leaves `result` unchanged, so bubbles are legal anywhere, including mid-frame.
- Push and pop in the same cycle: both happen and occupancy is unchanged. When full, `in_ready`=0 and pushes are blocked even if a pop occurs that cycle.
- FSM:
  - IDLE: a pop drives `accumulate_enable`=1. If the entry's `last`=0, go to ACTIVE; if `last`=1 (single-pair frame), stay IDLE.
  - ACTIVE: a pop drives `accumulate_enable`=0. If `last`=1, go to IDLE.
  - Bubbles never change state.
- Done tracking: issuing a pair with `last`=1 loads a MAC_LAT-stage shift register.
  - `frame_done`=1 exactly MAC_LAT cycles after the cycle the last pair is on `a`/`b`. `frame_count` increments on that same edge.
  - Back-to-back frames can have several done bits in flight; each produces its own pulse.
- `frame_count` wraps from 2^CNT_W-1 to 0.
- `busy` = (state==ACTIVE) | !fifo_empty | (|done_shift).

Decomposition:
- Package `macc_pkg`:
  - Constants DATA_W=32, RESULT_W=64, MAC_LAT=2.
  - State enum {IDLE, ACTIVE}.
  - Struct/typedef for a FIFO entry {a, b, last}.
- Sub-module `macc_operand_fifo`: synchronous FIFO, DEPTH entries, with full/empty flags, pointer wrap and an occupancy counter of log2(DEPTH)+1 bits. The FSM, output registers and done tracking stay in the top.

Test Plan:
- 3-pair frame: (0xFFFF0000,0x0F0F0F0F), (0x000000FF,0xFFFFFFFF), (0x12345678,0xFFFF0000 with last), `issue_en`=1.
  - `accumulate_enable`=1 only with the first pair.
  - `frame_done` 2 cycles after the third pair is on `a`/`b`; MAC `result`=0x000000001D3B00FF; `frame_count`=1.
- Single-pair frame (0xAAAAAAAA, 0xFFFFFFFF, last) straight after the previous frame → `accumulate_enable`=1, `result`=0xAAAAAAAA, two separate `frame_done` pulses, `frame_count`=2.
- Bubbles mid-frame: `issue_en`=0 for 3 cycles between pairs 1 and 2 of the first test → `a`=`b`=0 during the gap, final `result` still 0x1D3B00FF, `frame_done` delayed by 3 cycles.
- Backpressure: `issue_en`=0, push 5 pairs → 4 accepted, `in_ready`=0 from the cycle after the 4th; raise `issue_en` → `in_ready`=1 after the first pop and the 5th pair is accepted.
- Reset mid-frame: assert `rst` after pair 2 → next cycle all outputs 0, `busy`=0, `frame_count` unchanged at 0. A new frame afterwards starts with `accumulate_enable`=1.
- Wrap: CNT_W=2, run 5 single-pair frames → `frame_count` sequence 1,2,3,0,1.
